// File: rtl/nyq_rx_decim.sv
// Receive-side Nyquist matched filter: NTAPS delay line, decimate-by-DECIM, serial MAC per output.
// Define NYQ_RX_SAT_EN to saturate the shifted accumulator; otherwise it wraps to OUT_WIDTH bits.
module nyq_rx_decim #(
  parameter int ADDR_WIDTH = 11,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int NTAPS      = 16,
  parameter int DECIM      = 2,
  parameter int SHIFT      = 23
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
  input  logic [IN_WIDTH-1:0]         NYQ_In_DI,
  input  logic                        In_Valid_SI,
  output logic                        In_Ready_SO,
  output logic [OUT_WIDTH-1:0]        NYQ_Out_DO,
  output logic                        Out_Valid_SO
);

  localparam int TW = $clog2(NTAPS);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = MEM_WIDTH + IN_WIDTH;
  localparam int AW = PROD_W + TW;
  localparam logic [ADDR_WIDTH:0] NTAPS_A = (ADDR_WIDTH+1)'(NTAPS);
  localparam logic [TW-1:0] TAP_LAST = TW'(NTAPS - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                      state_q, state_d;
  logic signed [MEM_WIDTH-1:0] coef_q [NTAPS];
  logic signed [IN_WIDTH-1:0]  x_q [NTAPS];
  logic signed [AW-1:0]        acc_q, acc_d;
  logic [TW-1:0]               tap_q, tap_d;
  logic [PW-1:0]               phase_q, phase_d;
  logic [OUT_WIDTH-1:0]        out_q, out_d;
  logic                        valid_q, valid_d;

  logic                        accept;
  logic                        coef_we;
  logic signed [PROD_W-1:0]    prod;
  logic signed [AW-1:0]        shifted;
  logic [OUT_WIDTH-1:0]        reduced;

  assign In_Ready_SO  = (state_q == IDLE);
  assign NYQ_Out_DO   = out_q;
  assign Out_Valid_SO = valid_q;

  assign accept  = In_Valid_SI & In_Ready_SO;
  assign coef_we = WrEn_SI && (state_q == IDLE) && ({1'b0, Addr_DI} < NTAPS_A);
  assign prod    = coef_q[tap_q] * x_q[tap_q];
  assign shifted = acc_q >>> SHIFT;

`ifdef NYQ_RX_SAT_EN
  logic [AW-OUT_WIDTH:0] upper;
  assign upper = shifted[AW-1:OUT_WIDTH-1];
  // In range exactly when every bit above the output sign bit replicates it.
  always_comb begin
    reduced = shifted[OUT_WIDTH-1:0];
    if (!((&upper) || (~|upper)))
      reduced = shifted[AW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[AW-1:OUT_WIDTH];
  assign reduced   = shifted[OUT_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    phase_d = phase_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            acc_d   = '0;
            tap_d   = '0;
            state_d = MAC;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + {{TW{prod[PROD_W-1]}}, prod};
        if (tap_q == TAP_LAST) state_d = OUT;
        else                   tap_d   = tap_q + 1'b1;
      end
      OUT: begin
        out_d   = reduced;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      if (coef_we) coef_q[Addr_DI[TW-1:0]] <= PAR_In_DI;
      if (accept) begin
        for (int unsigned i = NTAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
        x_q[0] <= NYQ_In_DI;
      end
    end
  end

endmodule

// File: tb/tb_nyq_rx_decim.sv
// Self-checking bench for nyq_rx_decim: two instances (SHIFT=0, SHIFT=23) against a transaction-level model.
module tb_nyq_rx_decim;
  localparam int NTAPS = 16;
  localparam int DECIM = 2;
  localparam longint SENT = -999999999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [10:0] addr = '0;
  logic [23:0] par = '0;
  logic [23:0] din = '0;
  logic        in_valid = 1'b0;
  logic        ready0, ready23, valid0, valid23;
  logic [23:0] out0, out23;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nyq_rx_decim #(.ADDR_WIDTH(11), .MEM_WIDTH(24), .IN_WIDTH(24), .OUT_WIDTH(24),
                 .NTAPS(NTAPS), .DECIM(DECIM), .SHIFT(0)) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .WrEn_SI(wr_en), .Addr_DI(addr), .PAR_In_DI(par),
    .NYQ_In_DI(din), .In_Valid_SI(in_valid), .In_Ready_SO(ready0),
    .NYQ_Out_DO(out0), .Out_Valid_SO(valid0));

  nyq_rx_decim #(.ADDR_WIDTH(11), .MEM_WIDTH(24), .IN_WIDTH(24), .OUT_WIDTH(24),
                 .NTAPS(NTAPS), .DECIM(DECIM), .SHIFT(23)) u_dut23 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .WrEn_SI(wr_en), .Addr_DI(addr), .PAR_In_DI(par),
    .NYQ_In_DI(din), .In_Valid_SI(in_valid), .In_Ready_SO(ready23),
    .NYQ_Out_DO(out23), .Out_Valid_SO(valid23));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint mcoef [NTAPS];
  longint mhist [NTAPS];
  int     mphase = 0;
  int     mbusy = 0;
  longint mcyc = 0;
  longint mdue = -1;
  bit     mvalid = 1'b0;
  logic signed [23:0] mexp0 = '0, mexp23 = '0, mpend0 = '0, mpend23 = '0;

  function automatic logic signed [23:0] reduce(input longint a, input int sh);
    longint s;
    s = a >>> sh;
`ifdef NYQ_RX_SAT_EN
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
`endif
    return s[23:0];
  endfunction

  function void model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      mcoef[i] = 0;
      mhist[i] = 0;
    end
    mphase = 0; mbusy = 0; mdue = -1; mvalid = 1'b0;
    mexp0 = '0; mexp23 = '0;
  endfunction

  initial model_clear();
  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    longint acc;
    if (!rst_n) model_clear();
    else begin
      mcyc++;
      mvalid = 1'b0;
      if (mbusy == 0) begin
        if (wr_en && addr < NTAPS) mcoef[addr] = longint'($signed(par));
        if (in_valid) begin
          for (int i = NTAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
          mhist[0] = longint'($signed(din));
          if (mphase == DECIM - 1) begin
            mphase = 0;
            acc = 0;
            for (int i = 0; i < NTAPS; i++) acc += mcoef[i] * mhist[i];
            mpend0  = reduce(acc, 0);
            mpend23 = reduce(acc, 23);
            mdue  = mcyc + NTAPS + 1;
            mbusy = NTAPS + 1;
          end else mphase++;
        end
      end else mbusy--;
      if (mcyc == mdue) begin
        mvalid = 1'b1;
        mexp0  = mpend0;
        mexp23 = mpend23;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready0", longint'(ready0), longint'(mbusy == 0));
    chk("ready23", longint'(ready23), longint'(mbusy == 0));
    chk("valid0", longint'(valid0), longint'(mvalid));
    chk("valid23", longint'(valid23), longint'(mvalid));
    chk("out0", longint'($signed(out0)), longint'(mexp0));
    chk("out23", longint'($signed(out23)), longint'(mexp23));
  end

  // ---------------- output capture ----------------
  longint q0[$];
  longint q23[$];
  always @(negedge clk) begin
    if (valid0)  q0.push_back(longint'($signed(out0)));
    if (valid23) q23.push_back(longint'($signed(out23)));
  end

  function automatic longint qget(input bit which, input int i);
    if (which == 1'b0) return (i < q0.size()) ? q0[i] : SENT;
    return (i < q23.size()) ? q23[i] : SENT;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input longint d);
    wr_en = 1'b1; addr = 11'(a); par = 24'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send(input longint x);
    int n;
    din = 24'(x); in_valid = 1'b1; n = 0;
    while (!ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; wr_en = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    q0.delete(); q23.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_ready", ready0, 1);
    chk("rst_out", out0, 0);
    chk("rst_valid", valid0, 0);

    // impulse coefficient at tap 0, decimation picks every 2nd sample
    for (int i = 0; i < NTAPS; i++) wr(i, (i == 0) ? 1 : 0);
    send(5); send(7); send(9); send(11);
    in_valid = 1'b0;
    idle(NTAPS + 4);
    chk("t1_count", q0.size(), 2);
    chk("t1_out_a", qget(0, 0), 7);
    chk("t1_out_b", qget(0, 1), 11);

    // ramp coefficients, single impulse input
    do_reset();
    for (int i = 0; i < NTAPS; i++) wr(i, i + 1);
    send(1);
    for (int i = 0; i < 17; i++) send(0);
    in_valid = 1'b0;
    idle(NTAPS + 4);
    chk("t2_count", q0.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t2_out%0d", i), qget(0, i), (i < 8) ? 2 * (i + 1) : 0);

    // full-scale accumulation
    do_reset();
    for (int i = 0; i < NTAPS; i++) wr(i, 8388607);
    for (int i = 0; i < NTAPS; i++) send(8388607);
    in_valid = 1'b0;
    idle(NTAPS + 4);
`ifdef NYQ_RX_SAT_EN
    chk("t3_full0", qget(0, 7), 8388607);
    chk("t3_full23", qget(1, 7), 8388607);
`else
    chk("t3_full0", qget(0, 7), 16);
    chk("t3_full23", qget(1, 7), -32);
`endif

    // dropped writes: out-of-range address, and write during MAC
    do_reset();
    wr(0, 3);
    wr(16, 100);
    send(1); send(2);
    in_valid = 1'b0;
    wr_en = 1'b1; addr = 11'd0; par = 24'd50;
    @(negedge clk);
    wr_en = 1'b0;
    idle(NTAPS + 4);
    send(4); send(5);
    in_valid = 1'b0;
    idle(NTAPS + 4);
    chk("t4_out_a", qget(0, 0), 6);
    chk("t4_out_b", qget(0, 1), 15);

    // reset in the middle of a MAC pass
    q0.delete(); q23.delete();
    send(1); send(2);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_rst", out0, 0);
    chk("t5_valid_rst", valid0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(NTAPS + 8);
    chk("t5_no_pulse", q0.size(), 0);
    chk("t5_ready", ready0, 1);
    send(1000); send(-77); send(123456); send(5);
    in_valid = 1'b0;
    idle(NTAPS + 4);
    chk("t5_count", q0.size(), 2);
    chk("t5_zero_a", qget(0, 0), 0);
    chk("t5_zero_b", qget(0, 1), 0);

    // Q1.23 scaling keeps sign through the arithmetic shift
    do_reset();
    wr(0, 4194304);
    send(-8388608); send(-8388608);
    in_valid = 1'b0;
    idle(NTAPS + 4);
    chk("t6_q23", qget(1, 0), -4194304);

    // randomized traffic with interleaved coefficient writes
    do_reset();
    for (int i = 0; i < NTAPS; i++) wr(i, longint'($urandom_range(0, 32'hFFFFFF)));
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din      = 24'($urandom);
      wr_en    = ($urandom_range(0, 7) == 0);
      addr     = 11'($urandom_range(0, 20));
      par      = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; wr_en = 1'b0;
    idle(NTAPS + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nyq_rx_decim.md
Name: nyq_rx_decim

Overview:
- Receive-side Nyquist matched filter. It is the counterpart of the transmit NYQ shaping filter and sits after the channel/ADC front end.
- Accepts one sample per valid/ready handshake, stores NTAPS samples in a delay line, and decimates by DECIM.
- Produces each output with a single serial multiply-accumulate pass over the coefficient RAM.
- The coefficient RAM is loaded over the same WrEn/Addr/PAR_In write interface as the transmit filter.

Parameters:
- ADDR_WIDTH, 11: coefficient address width.
- MEM_WIDTH, 24: coefficient word width, signed.
- IN_WIDTH, 24: input sample width, signed.
- OUT_WIDTH, 24: output sample width, signed.
- NTAPS, 16: number of taps. Must satisfy 2 <= NTAPS <= 2^ADDR_WIDTH.
- DECIM, 2: decimation factor, >= 1.
- SHIFT, 23: arithmetic right shift applied to the accumulator before output (Q1.23 coefficients).

Ports:
- Clk_CI  in  1  clock, rising edge.
- Rst_RBI  in  1  asynchronous active-low reset.
- WrEn_SI  in  1  coefficient write enable.
- Addr_DI  in  ADDR_WIDTH  coefficient write address.
- PAR_In_DI  in  MEM_WIDTH  coefficient write data.
- NYQ_In_DI  in  IN_WIDTH  input sample.
- In_Valid_SI  in  1  input sample valid.
- In_Ready_SO  out  1  block can accept a sample.
- NYQ_Out_DO  out  OUT_WIDTH  filtered, decimated output; held between results.
- Out_Valid_SO  out  1  one-cycle strobe marking a new NYQ_Out_DO.

Behaviour:
- Reset (Rst_RBI=0, asynchronous) clears:
  - coefficient RAM, delay line, accumulator, tap counter and phase counter to 0;
  - NYQ_Out_DO=0, Out_Valid_SO=0;
  - FSM state to IDLE; In_Ready_SO=1 once reset is released.
- FSM states IDLE, MAC, OUT:
  - IDLE: In_Ready_SO=1. A sample is accepted on an edge where In_Valid_SI & In_Ready_SO.
  - On accept, the sample shifts into delay slot 0 (x[0]=newest, x[NTAPS-1]=oldest).
  - If the phase counter equals DECIM-1: phase resets to 0, accumulator clears, tap counter clears, go to MAC. Otherwise phase increments and the FSM stays in IDLE.
  - MAC: In_Ready_SO=0 for exactly NTAPS cycles. Each cycle adds c[t]*x[t] (full signed product, MEM_WIDTH+IN_WIDTH bits) for t = 0..NTAPS-1.
  - Accumulator width is MEM_WIDTH+IN_WIDTH+ceil(log2(NTAPS)) bits, so it cannot overflow.
  - After t = NTAPS-1, go to OUT.
  - OUT: one cycle, In_Ready_SO=0. On that edge NYQ_Out_DO is loaded with acc >>> SHIFT (arithmetic shift), reduced to OUT_WIDTH (see Optional Feature), and Out_Valid_SO is asserted. Next state is IDLE.
- Latency: for a decimating accept at edge k, Out_Valid_SO is high during cycle k+NTAPS+1 → k+NTAPS+2.
- Out_Valid_SO is high for exactly one cycle per result. NYQ_Out_DO holds its value until the next OUT.
- Coefficient writes:
  - Honoured only in IDLE, when WrEn_SI=1 and Addr_DI < NTAPS; they take effect on that edge.
  - Writes in MAC or OUT, or with Addr_DI >= NTAPS, are silently dropped.
  - Coefficient writes and sample accepts in the same IDLE cycle are both performed. The MAC pass uses the updated coefficient.
- In_Valid_SI while In_Ready_SO=0: no sample is taken and the delay line is unchanged. The source must hold its sample.
- Reset mid-MAC: the pass is aborted and no Out_Valid_SO is produced. Coefficients are lost and must be reloaded.
- Delay line is zero-filled after reset. Early outputs therefore see zeros for not-yet-received samples.

Optional Feature:
- Macro NYQ_RX_SAT_EN.
- Defined: the shifted accumulator is saturated to the OUT_WIDTH signed range. With OUT_WIDTH=24 the range is [-8388608, 8388607].
- Undefined: the shifted accumulator is truncated to its low OUT_WIDTH bits (two's-complement wrap).

Test Plan:
- Set SHIFT=0, c[0]=1, other taps 0. Input 5,7,9,11 with In_Valid_SI held high → outputs 7 then 11. Each Out_Valid_SO pulse comes NTAPS+1=17 cycles after the 2nd and 4th accepts. In_Ready_SO is low for 17 cycles after each of those accepts.
- Set SHIFT=0, c[i]=i+1. Input 1 followed by zeros → output sequence 2,4,6,8,10,12,14,16, then 0.
- Set SHIFT=0, all c=8388607, all inputs 8388607:
  - with NYQ_RX_SAT_EN → NYQ_Out_DO=8388607;
  - without it → NYQ_Out_DO equals the low 24 bits of 16*8388607^2.
- Write to Addr_DI=16 with data 100, and write c[0]=50 while in MAC → neither changes the RAM. A following impulse test shows the previously loaded c[0] and no effect from address 16.
- Drop Rst_RBI at the 5th cycle of MAC → Out_Valid_SO never pulses and NYQ_Out_DO=0. After release, In_Ready_SO=1 and all coefficients read as zero: any input gives output 0.
- Use SHIFT=23, c[0]=4194304 (0.5). Input -8388608, -8388608 → output -4194304, sign preserved by the arithmetic shift.
